// File: rtl/lynx_bfm_pkg.sv
// Lynx NoC BFM shared definitions: initiator state encoding, flit field
// positions and the pack/unpack helpers shared with the via models.
// Flit layout, MSB first:
//   {return_node, return_vc, src_node, dst_node, dst_vc, id[7:0], counter}
// Flits up to 64 bits wide are supported by the helpers.
package lynx_bfm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bfm_state_t;

    localparam int ID_WIDTH  = 8;
    localparam int FLIT_MAX  = 64;

    // Counter field takes whatever the routing fields and id leave over.
    function automatic int cnt_width(input int w, input int aw, input int vw);
        return w - 3 * aw - 2 * vw - ID_WIDTH;
    endfunction

    function automatic int id_pos(input int w, input int aw, input int vw);
        return cnt_width(w, aw, vw);
    endfunction

    function automatic int dvc_pos(input int w, input int aw, input int vw);
        return id_pos(w, aw, vw) + ID_WIDTH;
    endfunction

    function automatic int dnode_pos(input int w, input int aw, input int vw);
        return dvc_pos(w, aw, vw) + vw;
    endfunction

    function automatic int snode_pos(input int w, input int aw, input int vw);
        return dnode_pos(w, aw, vw) + aw;
    endfunction

    function automatic int rvc_pos(input int w, input int aw, input int vw);
        return snode_pos(w, aw, vw) + aw;
    endfunction

    function automatic int rnode_pos(input int w, input int aw, input int vw);
        return rvc_pos(w, aw, vw) + vw;
    endfunction

    function automatic logic [FLIT_MAX-1:0] field_mask(input int fw);
        return (fw >= FLIT_MAX) ? '1 : ((64'd1 << fw) - 64'd1);
    endfunction

    // Assemble a flit; each field is masked to its width before placement.
    function automatic logic [FLIT_MAX-1:0] pack_flit(
        input int w, input int aw, input int vw,
        input logic [FLIT_MAX-1:0] rnode, input logic [FLIT_MAX-1:0] rvc,
        input logic [FLIT_MAX-1:0] snode, input logic [FLIT_MAX-1:0] dnode,
        input logic [FLIT_MAX-1:0] dvc,   input logic [FLIT_MAX-1:0] id,
        input logic [FLIT_MAX-1:0] cnt);
        logic [FLIT_MAX-1:0] f;
        f = ((rnode & field_mask(aw)) << rnode_pos(w, aw, vw))
          | ((rvc   & field_mask(vw)) << rvc_pos(w, aw, vw))
          | ((snode & field_mask(aw)) << snode_pos(w, aw, vw))
          | ((dnode & field_mask(aw)) << dnode_pos(w, aw, vw))
          | ((dvc   & field_mask(vw)) << dvc_pos(w, aw, vw))
          | ((id    & field_mask(ID_WIDTH)) << id_pos(w, aw, vw))
          |  (cnt   & field_mask(cnt_width(w, aw, vw)));
        return f;
    endfunction

    // Extract one field of width fw starting at bit pos.
    function automatic logic [FLIT_MAX-1:0] unpack_field(
        input logic [FLIT_MAX-1:0] flit, input int pos, input int fw);
        return (flit >> pos) & field_mask(fw);
    endfunction

endpackage

// File: rtl/req_init_credit.sv
// Outstanding-request tracker for the Lynx initiator BFM.
// inc on each request transfer, dec on each accepted reply; inc and dec in the
// same cycle cancel. A dec at zero is flagged on underflow and ignored, so the
// count saturates at zero.
module req_init_credit #(
    parameter int MAX_COUNT = 4,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          underflow
);

    logic dec_ok;

    assign underflow = dec && (count == '0);
    assign dec_ok    = dec && !underflow;

    // Counter update; async active-low reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec_ok) begin
            count <= count + 1'b1;
        end else if (!inc && dec_ok) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/req_init_1_1.sv
// Lynx NoC initiator BFM (return-to-sender partner of a via).
// Issues request flits stamped with the reply port as return address,
// round-robin over a destination list, bounded by MAX_OUTSTANDING in flight.
// Replies are checked for their destination node; done rises once every
// request has been answered. Optional trace output: define LYNX_TRACE_EN.
// Handshake: a flit moves on any clk where valid & ready are both high; the
// sender holds data/dest/vc stable while valid is high and ready is low.
module req_init_1_1
    import lynx_bfm_pkg::*;
#(
    parameter int N               = 16,
    parameter int NUM_VC          = 2,
    parameter int N_ADDR_WIDTH    = $clog2(N),
    parameter int VC_ADDR_WIDTH   = $clog2(NUM_VC),
    parameter int i0_WIDTH        = 32,
    parameter int o0_WIDTH        = 32,
    parameter int o0_ID           = 0,
    parameter int i0_ID           = 0,
    parameter int o0_NODE         = 15,
    parameter int i0_NODE         = 15,
    parameter int i0_VC           = 0,
    parameter int o0_NUM_DEST     = 4,
    parameter logic [o0_NUM_DEST*N_ADDR_WIDTH-1:0]  o0_DEST = {o0_NUM_DEST{N_ADDR_WIDTH'(1)}},
    parameter logic [o0_NUM_DEST*VC_ADDR_WIDTH-1:0] o0_VC   = {o0_NUM_DEST{VC_ADDR_WIDTH'(1)}},
    parameter int MAX_OUTSTANDING = 4,
    parameter int NUM_REQ         = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     done,
    output logic                     err,
    input  logic [i0_WIDTH-1:0]      i0_data_in,
    input  logic                     i0_valid_in,
    output logic                     i0_ready_out,
    output logic [o0_WIDTH-1:0]      o0_data_out,
    output logic [N_ADDR_WIDTH-1:0]  o0_dest_out,
    output logic [VC_ADDR_WIDTH-1:0] o0_vc_out,
    output logic                     o0_valid_out,
    input  logic                     o0_ready_in
);

    localparam int CNT_W   = cnt_width(o0_WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int DI_W    = (o0_NUM_DEST > 1) ? $clog2(o0_NUM_DEST) : 1;
    localparam int RSP_DNP = dnode_pos(i0_WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH);

    // Elaboration checks: the counter field must hold NUM_REQ.
    if (CNT_W < 1 || (64'(NUM_REQ) >> CNT_W) != 64'd0) begin : g_cnt_chk
        $error("req_init_1_1: NUM_REQ does not fit the flit counter field");
    end
    if (o0_WIDTH > FLIT_MAX || i0_WIDTH > FLIT_MAX) begin : g_width_chk
        $error("req_init_1_1: flit wider than 64 bits");
    end
    if (MAX_OUTSTANDING < 1 || o0_NUM_DEST < 1) begin : g_cfg_chk
        $error("req_init_1_1: MAX_OUTSTANDING and o0_NUM_DEST must be >= 1");
    end
    if (o0_ID > 255 || i0_ID > 255) begin : g_id_chk
        $error("req_init_1_1: ids are 8-bit");
    end

    bfm_state_t               state;
    logic [CNT_W-1:0]         req_cnt;
    logic [CNT_W-1:0]         rsp_cnt;
    logic [DI_W-1:0]          dst_idx;
    logic [DI_W-1:0]          dst_idx_nxt;
    logic [OUT_W-1:0]         outstanding;
    logic [N_ADDR_WIDTH-1:0]  next_dest;
    logic [VC_ADDR_WIDTH-1:0] next_vc;
    logic                     req_xfer;
    logic                     rsp_take;
    logic                     underflow;
    logic                     bad_route;
    logic                     can_load;

    assign req_xfer = o0_valid_out && o0_ready_in;
    assign rsp_take = i0_valid_in && i0_ready_out;

    req_init_credit #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CW        (OUT_W)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (req_xfer),
        .dec       (rsp_take),
        .count     (outstanding),
        .underflow (underflow)
    );

    // Destination index after this cycle's transfer; a flit loaded in the
    // same cycle its predecessor leaves must already use the next entry.
    always_comb begin
        dst_idx_nxt = dst_idx;
        if (req_xfer) begin
            dst_idx_nxt = (dst_idx == DI_W'(o0_NUM_DEST - 1)) ? '0 : dst_idx + 1'b1;
        end
        next_dest = o0_DEST[int'(dst_idx_nxt)*N_ADDR_WIDTH +: N_ADDR_WIDTH];
        next_vc   = o0_VC[int'(dst_idx_nxt)*VC_ADDR_WIDTH +: VC_ADDR_WIDTH];
    end

    // A held flit counts against the limit whether or not it leaves this cycle.
    assign can_load = (state == ST_SEND)
                   && (!o0_valid_out || o0_ready_in)
                   && ((int'(outstanding) + int'(o0_valid_out)) < MAX_OUTSTANDING)
                   && (req_cnt < CNT_W'(NUM_REQ));

    assign bad_route = rsp_take &&
        (unpack_field(64'(i0_data_in), RSP_DNP, N_ADDR_WIDTH) != 64'(i0_NODE));

    // Main FSM with registered outputs, sticky error and reply counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            req_cnt      <= '0;
            rsp_cnt      <= '0;
            dst_idx      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            i0_ready_out <= 1'b0;
            o0_data_out  <= '0;
            o0_dest_out  <= '0;
            o0_vc_out    <= '0;
            o0_valid_out <= 1'b0;
        end else begin
            if (underflow || bad_route) begin
                err <= 1'b1;
            end
            if (rsp_take && !underflow) begin
                rsp_cnt <= rsp_cnt + 1'b1;
            end
            if (req_xfer) begin
                dst_idx <= dst_idx_nxt;
            end
            case (state)
                ST_IDLE: begin
                    i0_ready_out <= 1'b1;
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (can_load) begin
                        req_cnt      <= req_cnt + 1'b1;
                        o0_data_out  <= o0_WIDTH'(pack_flit(o0_WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH,
                                            64'(i0_NODE), 64'(i0_VC), 64'(o0_NODE),
                                            64'(next_dest), 64'(next_vc), 64'(o0_ID),
                                            64'(req_cnt + 1'b1)));
                        o0_dest_out  <= next_dest;
                        o0_vc_out    <= next_vc;
                        o0_valid_out <= 1'b1;
                    end else if (req_xfer) begin
                        o0_valid_out <= 1'b0;
                    end
                    if (req_xfer && req_cnt == CNT_W'(NUM_REQ)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == '0 && rsp_cnt == CNT_W'(NUM_REQ)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    done <= 1'b1;
                end
            endcase
        end
    end

`ifdef LYNX_TRACE_EN
    // Trace every request transfer, reply and error event.
    always @(posedge clk) begin
        if (rst && req_xfer) begin
            $display("SRC=%0d; time=%0t; from=%0d; to=%0d; curr=%0d; data=%h;",
                     o0_ID, $time, o0_NODE, o0_dest_out, o0_NODE, o0_data_out);
        end
        if (rst && rsp_take) begin
            $display("SINK=%0d; time=%0t; from=%0d; to=%0d; curr=%0d; data=%h; SRC=%0d;",
                     i0_ID, $time,
                     unpack_field(64'(i0_data_in), snode_pos(i0_WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH), N_ADDR_WIDTH),
                     i0_NODE, i0_NODE, i0_data_in,
                     unpack_field(64'(i0_data_in), id_pos(i0_WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH), ID_WIDTH));
        end
        if (rst && (underflow || bad_route)) begin
            $display("ERR=1;");
        end
    end
`endif

endmodule

// File: tb/tb_req_init_1_1.sv
// Directed bench for the Lynx initiator BFM. dut_a: default destinations,
// NUM_REQ=8, MAX_OUTSTANDING=4. dut_b: destinations {2,5,7} with a toggling
// ready. Inputs change 2 time units after posedge; handshakes are sampled on
// the negedge, which sees exactly what the next posedge will act on.
module tb_req_init_1_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b;
    logic        a_done, a_err, a_i0_ready, a_valid, a_ready_in, a_i0_valid;
    logic [31:0] a_i0_data, a_data;
    logic [3:0]  a_dest;
    logic        a_vc;
    logic        b_done, b_err, b_i0_ready, b_valid, b_ready, b_i0_valid;
    logic [31:0] b_i0_data, b_data;
    logic [3:0]  b_dest;
    logic        b_vc;

    int tests, fails, cyc;
    int a_xfers, a_replies, b_xfers;
    bit via_en, drv_is_via, b_toggle, b_stalled;
    logic [31:0] b_held;
    logic [31:0] exp_q[$];
    logic [31:0] exp_b_q[$];
    logic [3:0]  exp_b_dest_q[$];
    logic [31:0] via_q[$];
    int          via_due[$];

    req_init_1_1 #(.NUM_REQ(8), .MAX_OUTSTANDING(4)) dut_a (
        .clk(clk), .rst(rst), .done(a_done), .err(a_err),
        .i0_data_in(a_i0_data), .i0_valid_in(a_i0_valid), .i0_ready_out(a_i0_ready),
        .o0_data_out(a_data), .o0_dest_out(a_dest), .o0_vc_out(a_vc),
        .o0_valid_out(a_valid), .o0_ready_in(a_ready_in));

    req_init_1_1 #(.NUM_REQ(8), .MAX_OUTSTANDING(4), .o0_NUM_DEST(3), .o0_DEST(12'h752)) dut_b (
        .clk(clk), .rst(rst_b), .done(b_done), .err(b_err),
        .i0_data_in(b_i0_data), .i0_valid_in(b_i0_valid), .i0_ready_out(b_i0_ready),
        .o0_data_out(b_data), .o0_dest_out(b_dest), .o0_vc_out(b_vc),
        .o0_valid_out(b_valid), .o0_ready_in(b_ready));

    // Expected request: return 15/vc0, src 15, dst/vc, id 0, counter.
    function automatic logic [31:0] req_flit(input logic [3:0] dst, input logic vc, input logic [9:0] cnt);
        return {4'd15, 1'b0, 4'd15, dst, vc, 8'd0, cnt};
    endfunction

    // Reply as a via would send it back: routed to node dst.
    function automatic logic [31:0] rsp_flit(input logic [3:0] dst, input logic [9:0] cnt);
        return {4'd1, 1'b1, 4'd1, dst, 1'b0, 8'd0, cnt};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, then drive after posedge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_valid && a_ready_in) begin
            a_xfers++;
            check("a_xfer_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("a_req_flit", 64'(a_data), 64'(exp_q.pop_front()));
            check("a_dest_port", 64'(a_dest), 64'd1);
            if (via_en) begin
                via_q.push_back(rsp_flit(4'd15, a_data[9:0]));
                via_due.push_back(cyc + 3);
            end
        end
        if (a_i0_valid && a_i0_ready) begin
            a_replies++;
            if (drv_is_via) begin
                void'(via_q.pop_front());
                void'(via_due.pop_front());
            end
        end
        if (b_valid) begin
            if (b_stalled) check("b_stable", 64'(b_data), 64'(b_held));
            if (b_ready) begin
                b_xfers++;
                check("b_xfer_expected", 64'(exp_b_q.size() > 0), 64'd1);
                if (exp_b_q.size() > 0) begin
                    check("b_req_flit", 64'(b_data), 64'(exp_b_q.pop_front()));
                    check("b_dest_port", 64'(b_dest), 64'(exp_b_dest_q.pop_front()));
                end
            end
            b_stalled = !b_ready;
            b_held    = b_data;
        end else begin
            b_stalled = 1'b0;
        end
        @(posedge clk);
        #2;
        if (b_toggle) b_ready = ~b_ready;
        drv_is_via = 1'b0;
        a_i0_valid = 1'b0;
        if (via_en && via_q.size() > 0 && via_due[0] <= cyc) begin
            a_i0_valid = 1'b1;
            a_i0_data  = via_q[0];
            drv_is_via = 1'b1;
        end
    endtask

    // Asynchronous reset of dut_a off a clock edge, then release.
    task automatic reset_a(input string tag);
        #1;
        rst        = 1'b0;
        a_i0_valid = 1'b0;
        via_en     = 1'b0;
        via_q.delete();
        via_due.delete();
        exp_q.delete();
        a_xfers   = 0;
        a_replies = 0;
        #1;
        check({tag, "_valid0"}, 64'(a_valid), 64'd0);
        check({tag, "_data0"}, 64'(a_data), 64'd0);
        check({tag, "_done0"}, 64'(a_done), 64'd0);
        check({tag, "_err0"}, 64'(a_err), 64'd0);
        check({tag, "_ready0"}, 64'(a_i0_ready), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        a_xfers = 0; a_replies = 0; b_xfers = 0;
        via_en = 0; drv_is_via = 0; b_toggle = 0; b_stalled = 0; b_held = '0;
        a_ready_in = 0; a_i0_valid = 0; a_i0_data = '0;
        b_ready = 0; b_i0_valid = 0; b_i0_data = '0;
        rst = 1'b1; rst_b = 1'b1;
        #1;
        rst = 1'b0; rst_b = 1'b0;
        #1;
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_data", 64'(a_data), 64'd0);
        check("rst_dest", 64'(a_dest), 64'd0);
        check("rst_vc", 64'(a_vc), 64'd0);
        check("rst_i0_ready", 64'(a_i0_ready), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);

        // No replies: the outstanding limit stops issue at 4.
        @(posedge clk);
        #2;
        rst = 1'b1; rst_b = 1'b1;
        a_ready_in = 1'b1;
        b_ready = 1'b1; b_toggle = 1'b1;
        for (int k = 1; k <= 4; k++) exp_q.push_back(req_flit(4'd1, 1'b1, 10'(k)));
        for (int k = 1; k <= 4; k++) begin
            logic [3:0] d;
            d = (k % 3 == 1) ? 4'd2 : (k % 3 == 2) ? 4'd5 : 4'd7;
            exp_b_q.push_back(req_flit(d, 1'b1, 10'(k)));
            exp_b_dest_q.push_back(d);
        end
        tick();
        check("c1_valid", 64'(a_valid), 64'd0);
        check("c1_i0_ready", 64'(a_i0_ready), 64'd1);
        tick();
        check("c2_valid", 64'(a_valid), 64'd1);
        check("c2_counter", 64'(a_data), 64'(req_flit(4'd1, 1'b1, 10'd1)));
        repeat (20) tick();
        check("lim_xfers", 64'(a_xfers), 64'd4);
        check("lim_valid_low", 64'(a_valid), 64'd0);
        check("lim_done", 64'(a_done), 64'd0);
        check("lim_exp_left", 64'(exp_q.size()), 64'd0);
        check("b_xfers", 64'(b_xfers), 64'd4);
        check("b_exp_left", 64'(exp_b_q.size()), 64'd0);
        check("b_err", 64'(b_err), 64'd0);
        b_toggle = 1'b0;

        // Loopback via: all 8 requests answered.
        reset_a("r1");
        via_en = 1'b1;
        for (int k = 1; k <= 8; k++) exp_q.push_back(req_flit(4'd1, 1'b1, 10'(k)));
        for (int i = 0; i < 200 && !a_done; i++) tick();
        check("lb_done", 64'(a_done), 64'd1);
        check("lb_xfers", 64'(a_xfers), 64'd8);
        check("lb_replies", 64'(a_replies), 64'd8);
        check("lb_err", 64'(a_err), 64'd0);
        check("lb_valid", 64'(a_valid), 64'd0);
        repeat (3) tick();
        check("lb_done_held", 64'(a_done), 64'd1);

        // Transfer and reply on the same edge at outstanding=2.
        reset_a("r2");
        for (int k = 1; k <= 8; k++) exp_q.push_back(req_flit(4'd1, 1'b1, 10'(k)));
        for (int i = 0; i < 20; i++) begin
            if (dut_a.outstanding == 3'd2 && a_valid) break;
            tick();
        end
        check("sc_pre_out", 64'(dut_a.outstanding), 64'd2);
        a_i0_valid = 1'b1;
        a_i0_data  = rsp_flit(4'd15, 10'd1);
        begin
            int xb, rb;
            xb = a_xfers; rb = a_replies;
            tick();
            check("sc_xfer", 64'(a_xfers - xb), 64'd1);
            check("sc_reply", 64'(a_replies - rb), 64'd1);
        end
        check("sc_out", 64'(dut_a.outstanding), 64'd2);
        check("sc_err", 64'(a_err), 64'd0);

        // Unsolicited reply at outstanding=0.
        reset_a("r3");
        a_ready_in = 1'b0;
        tick(); tick();
        a_i0_valid = 1'b1;
        a_i0_data  = rsp_flit(4'd15, 10'd1);
        tick();
        check("uns_err", 64'(a_err), 64'd1);
        check("uns_out", 64'(dut_a.outstanding), 64'd0);

        // Misrouted reply (dst_node=3) still counts.
        reset_a("r4");
        a_ready_in = 1'b1;
        exp_q.push_back(req_flit(4'd1, 1'b1, 10'd1));
        for (int i = 0; i < 10 && dut_a.outstanding != 3'd1; i++) tick();
        check("mr_pre_out", 64'(dut_a.outstanding), 64'd1);
        a_ready_in = 1'b0;
        a_i0_valid = 1'b1;
        a_i0_data  = rsp_flit(4'd3, 10'd1);
        tick();
        check("mr_err", 64'(a_err), 64'd1);
        check("mr_out", 64'(dut_a.outstanding), 64'd0);

        // Reset mid-drain, then restart from counter 1.
        reset_a("r5");
        a_ready_in = 1'b1;
        via_en = 1'b1;
        for (int k = 1; k <= 8; k++) exp_q.push_back(req_flit(4'd1, 1'b1, 10'(k)));
        for (int i = 0; i < 200 && a_xfers < 8; i++) tick();
        check("dr_xfers", 64'(a_xfers), 64'd8);
        check("dr_not_done", 64'(a_done), 64'd0);
        check("dr_out_nz", 64'(dut_a.outstanding != 3'd0), 64'd1);
        reset_a("r6");
        for (int k = 1; k <= 4; k++) exp_q.push_back(req_flit(4'd1, 1'b1, 10'(k)));
        repeat (12) tick();
        check("rs_xfers", 64'(a_xfers), 64'd4);
        check("rs_err", 64'(a_err), 64'd0);
        check("rs_exp_left", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

endmodule
